dcache: RTL and testbench
=========================

// Module: dcache
// PURPOSE
//  Direct-mapped, write-through, no-write-allocate L1 data cache. It answers the MEM stage's
//  cache_rd/cache_wr/cache_waitrequest requests and refills lines from a backing memory port.
//  The backing memory port uses the same request/waitrequest protocol as the CPU port.
//  Read hits complete combinationally: waitrequest=0 and data valid in the request cycle.
// PARAMETERS
//  ADDR_WIDTH  32  byte address width, both ports
//  DATA_WIDTH  32  word width; fixed at 32, BE_WIDTH=DATA_WIDTH/8
//  LINES       64  number of lines (power of 2); IDX_W=$clog2(LINES)
//  LINE_WORDS  4   words per line (power of 2); OFF_W=$clog2(LINE_WORDS)
// PORTS
//  clock             in   1   rising-edge clock
//  reset             in   1   synchronous, active-high
//  cache_rd          in   1   CPU read request; held stable while cache_waitrequest=1
//  cache_wr          in   1   CPU write request; held stable while cache_waitrequest=1
//  cache_addr        in   32  byte address; [1:0] ignored
//  cache_wr_data     in   32  write data, lane-aligned
//  cache_wr_be       in   4   byte enables; be[i] enables data[8i+7:8i]
//  cache_data        out  32  read data; valid when cache_rd & ~cache_waitrequest
//  cache_waitrequest out  1   stall; 0 when no request is active
//  mem_rd            out  1   memory read request
//  mem_wr            out  1   memory write request
//  mem_addr          out  32  word-aligned memory address
//  mem_wr_data       out  32  memory write data
//  mem_wr_be         out  4   memory byte enables
//  mem_rd_data       in   32  memory read data; valid when mem_rd & ~mem_waitrequest
//  mem_waitrequest   in   1   memory stall; a transfer is accepted in any cycle it is 0
// BEHAVIOUR
//  Address split: offset=addr[OFF_W+1:2], index=addr[IDX_W+OFF_W+1:OFF_W+2], tag=remaining upper bits.
//  Storage: valid[LINES], tag[LINES], data[LINES*LINE_WORDS] words; all reads are asynchronous.
//  Hit = valid[index] & (tag[index]==addr tag).
//  FSM states: IDLE, FILL.
//  IDLE, cache_rd, hit:
//   - cache_waitrequest=0; cache_data=data[index][offset]; memory port idle.
//  IDLE, cache_rd, miss:
//   - cache_waitrequest=1.
//   - Register line base address {tag,index,OFF_W'0,2'b0}; word_cnt<=0; next state FILL.
//  FILL:
//   - cache_waitrequest=1; mem_rd=1; mem_addr=base+4*word_cnt.
//   - On each accept (mem_waitrequest=0): write mem_rd_data into data[idx][word_cnt]; word_cnt++.
//   - On the last accept: tag<=registered tag; valid<=1; next state IDLE.
//   - The retried read then hits.
//   - Miss with zero memory wait: waitrequest high for 1+LINE_WORDS cycles; data in the next cycle.
//  IDLE, cache_wr (write-through, pass-through path):
//   - mem_wr=1; mem_addr={cache_addr[31:2],2'b0}; mem_wr_data and mem_wr_be copy the CPU inputs.
//   - cache_waitrequest=mem_waitrequest.
//   - In the accept cycle, on a hit, merge the enabled bytes into the cached word.
//   - On a miss, leave cache state unchanged (no allocate).
//  cache_rd & cache_wr together: treated as a write; cache_data is don't-care.
//  A request arriving in FILL cannot occur (upstream is stalled); the CPU address is ignored in FILL.
//  Reset, including mid-FILL:
//   - state<=IDLE; all valid<=0; word_cnt<=0.
//   - mem_rd/mem_wr are low from the next cycle; the partial line is discarded.
//  Reset values: cache_waitrequest=0, mem_rd=0, mem_wr=0 (with no request active); mem_addr=0.
//  Data and tag arrays are not reset.
// CONFIGURATION
//  DCACHE_STATS_EN defined:
//   - adds outputs stat_hits[31:0] and stat_misses[31:0].
//   - stat_hits += 1 per completed read hit that is not a post-fill retry.
//   - stat_misses += 1 per IDLE->FILL transition.
//   - both counters wrap; both cleared by reset.
//  DCACHE_STATS_EN undefined: these ports and counters do not exist.
// STRUCTURE
//  pipTypes gains: dcache_state_t enum {DC_IDLE, DC_FILL}.
//  Sub-module dcache_tagstore: valid and tag arrays.
//   - async lookup port: index -> hit.
//   - sync write port: index, tag, set_valid.
//   - sync clear-all on reset.
//  The data array, FSM and word counter stay in dcache.
// TESTING (LINES=64, LINE_WORDS=4, memory model with zero wait unless stated)
//  1 Read miss after reset, rd 0x100:
//    - mem_rd at 0x100, 0x104, 0x108, 0x10C on consecutive cycles.
//    - waitrequest high 5 cycles, then cache_data=mem[0x100] with waitrequest=0.
//  2 After test 1, rd 0x108: hit in the same cycle, waitrequest=0, cache_data=mem[0x108], mem_rd never asserted.
//  3 Store hit, wr 0x100 be=4'b1000 data=0xAB000000, mem_waitrequest high 2 cycles:
//    - cache_waitrequest mirrors it; mem_wr_be=4'b1000.
//    - A later rd 0x100 hits and returns {8'hAB, old[23:0]}.
//  4 Store miss, wr 0x2000: exactly one mem_wr, no fill; a following rd 0x2000 misses and fills.
//  5 Conflict, rd 0x500 (same index 0x10 as 0x100): evicts; a following rd 0x100 misses again.
//  6 Reset asserted after the 2nd fill word of rd 0x100:
//    - next cycle mem_rd=0, waitrequest=0.
//    - rd 0x100 then misses and performs a full 4-word fill.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped write-through data cache.
package dcache_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int BE_WIDTH   = DATA_WIDTH / 8;

  typedef enum logic [0:0] {
    DC_IDLE = 1'b0,
    DC_FILL = 1'b1
  } dcache_state_t;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [BE_WIDTH-1:0]   be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < BE_WIDTH; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dcache_if.sv
// Request/waitrequest bus used by both the CPU side and the backing-memory side of the cache.
interface dcache_if;
  logic                              rd;
  logic                              wr;
  logic [dcache_pkg::ADDR_WIDTH-1:0] addr;
  logic [dcache_pkg::DATA_WIDTH-1:0] wr_data;
  logic [dcache_pkg::BE_WIDTH-1:0]   wr_be;
  logic [dcache_pkg::DATA_WIDTH-1:0] rd_data;
  logic                              waitrequest;

  modport master (output rd, wr, addr, wr_data, wr_be, input rd_data, waitrequest);
  modport slave  (input rd, wr, addr, wr_data, wr_be, output rd_data, waitrequest);
endinterface

// File: rtl/dcache_tagstore.sv
// Valid bits and tags: asynchronous hit lookup, synchronous single-entry write, clear-all on reset.
module dcache_tagstore #(
  parameter int LINES = 64,
  parameter int IDX_W = 6,
  parameter int TAG_W = 22
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IDX_W-1:0] lk_idx_i,
  input  logic [TAG_W-1:0] lk_tag_i,
  output logic             hit_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic             wr_valid_i
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [LINES];

  assign hit_o = valid_q[lk_idx_i] && (tag_q[lk_idx_i] == lk_tag_i);

  // Valid bits are the only cleared state; a reset mid-fill drops the partial line.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= wr_valid_i;
    end
  end

  // Tag storage
  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i] <= wr_tag_i;
    end
  end

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache with line refill FSM.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module dcache
  import dcache_pkg::*;
#(
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clock,
  input  logic        reset,
  dcache_if.slave     cpu,
  dcache_if.master    mem
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W - 2;

  dcache_state_t         state_q, state_d;
  logic [OFF_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;

  logic [DATA_WIDTH-1:0] data_q [LINES*LINE_WORDS];

  logic [IDX_W-1:0] req_idx_s, fill_idx_s;
  logic [OFF_W-1:0] req_off_s;
  logic [TAG_W-1:0] req_tag_s, fill_tag_s;
  logic             hit_s, fill_we_s, store_we_s, tag_we_s;

  assign req_off_s  = cpu.addr[OFF_W+1:2];
  assign req_idx_s  = cpu.addr[IDX_W+OFF_W+1:OFF_W+2];
  assign req_tag_s  = cpu.addr[ADDR_WIDTH-1:IDX_W+OFF_W+2];
  assign fill_idx_s = base_q[IDX_W+OFF_W+1:OFF_W+2];
  assign fill_tag_s = base_q[ADDR_WIDTH-1:IDX_W+OFF_W+2];

  dcache_tagstore #(.LINES(LINES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_tagstore (
    .clock      (clock),
    .reset      (reset),
    .lk_idx_i   (req_idx_s),
    .lk_tag_i   (req_tag_s),
    .hit_o      (hit_s),
    .wr_en_i    (tag_we_s),
    .wr_idx_i   (fill_idx_s),
    .wr_tag_i   (fill_tag_s),
    .wr_valid_i (1'b1)
  );

  // Next-state and bus outputs; reads and write-through stores are served straight from IDLE.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    base_d          = base_q;
    cpu.waitrequest = 1'b0;
    cpu.rd_data     = data_q[{req_idx_s, req_off_s}];
    mem.rd          = 1'b0;
    mem.wr          = 1'b0;
    mem.addr        = '0;
    mem.wr_data     = cpu.wr_data;
    mem.wr_be       = cpu.wr_be;
    fill_we_s       = 1'b0;
    store_we_s      = 1'b0;
    tag_we_s        = 1'b0;
    case (state_q)
      DC_IDLE: begin
        if (cpu.wr) begin
          mem.wr          = 1'b1;
          mem.addr        = {cpu.addr[ADDR_WIDTH-1:2], 2'b00};
          cpu.waitrequest = mem.waitrequest;
          store_we_s      = ~mem.waitrequest & hit_s;
        end else if (cpu.rd && !hit_s) begin
          cpu.waitrequest = 1'b1;
          state_d         = DC_FILL;
          base_d          = {cpu.addr[ADDR_WIDTH-1:OFF_W+2], {(OFF_W+2){1'b0}}};
          cnt_d           = '0;
        end else begin
          state_d = DC_IDLE;
        end
      end
      DC_FILL: begin
        cpu.waitrequest = 1'b1;
        mem.rd          = 1'b1;
        mem.addr        = {base_q[ADDR_WIDTH-1:OFF_W+2], cnt_q, 2'b00};
        if (!mem.waitrequest) begin
          fill_we_s = 1'b1;
          cnt_d     = cnt_q + OFF_W'(1);
          if (cnt_q == OFF_W'(LINE_WORDS - 1)) begin
            tag_we_s = 1'b1;
            state_d  = DC_IDLE;
          end else begin
            state_d = DC_FILL;
          end
        end else begin
          state_d = DC_FILL;
        end
      end
      default: begin
        state_d = DC_IDLE;
      end
    endcase
  end

  // FSM, word counter and line base registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= DC_IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
    end
  end

  // Data array: refill words, or merge enabled bytes of an accepted store hit.
  always_ff @(posedge clock) begin
    if (fill_we_s) begin
      data_q[{fill_idx_s, cnt_q}] <= mem.rd_data;
    end else if (store_we_s) begin
      data_q[{req_idx_s, req_off_s}] <=
        merge_bytes(data_q[{req_idx_s, req_off_s}], cpu.wr_data, cpu.wr_be);
    end
  end

`ifdef DCACHE_STATS_EN
  logic        retry_q;
  logic [31:0] hits_q, misses_q;

  // The first IDLE cycle after a fill is the stalled read's retry and is not counted as a hit.
  always_ff @(posedge clock) begin
    if (reset) begin
      retry_q  <= 1'b0;
      hits_q   <= 32'd0;
      misses_q <= 32'd0;
    end else begin
      retry_q <= tag_we_s;
      if (state_q == DC_IDLE && cpu.rd && !cpu.wr && hit_s && !retry_q) begin
        hits_q <= hits_q + 32'd1;
      end
      if (state_q == DC_IDLE && state_d == DC_FILL) begin
        misses_q <= misses_q + 32'd1;
      end
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`endif

endmodule

// File: tb/tb_dcache.sv
// Directed self-checking bench for dcache against a zero/configurable-wait backing memory model.
module tb_dcache;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   rd_acc   = 0;
  int   wr_acc   = 0;

  logic [31:0] wa [8];
  logic [31:0] wd [8];
  int          wn = 0;

  dcache_if cpu_bus();
  dcache_if mem_bus();

  dcache dut (
    .clock (clk),
    .reset (rst),
    .cpu   (cpu_bus),
    .mem   (mem_bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {16'hBEEF ^ a[17:2], 16'h1234 + a[17:2]};
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = pat(a);
    for (int i = 0; i < 8; i++) begin
      if (i < wn && wa[i] == a) w = wd[i];
    end
    return w;
  endfunction

  function automatic logic [31:0] be_merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] be);
    return {be[3] ? d[31:24] : o[31:24], be[2] ? d[23:16] : o[23:16],
            be[1] ? d[15:8]  : o[15:8],  be[0] ? d[7:0]   : o[7:0]};
  endfunction

  // Backing memory: read data presented mid-cycle, writes and accepts recorded at the clock edge.
  always @(negedge clk) mem_bus.rd_data <= mem_word(mem_bus.addr);

  always @(posedge clk) begin
    if (mem_bus.rd && !mem_bus.waitrequest) rd_acc <= rd_acc + 1;
    if (mem_bus.wr && !mem_bus.waitrequest) begin
      wr_acc <= wr_acc + 1;
      if (wn < 8) begin
        wa[wn] <= mem_bus.addr;
        wd[wn] <= be_merge(mem_word(mem_bus.addr), mem_bus.wr_data, mem_bus.wr_be);
        wn     <= wn + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full read miss: one stall cycle in IDLE, LINE_WORDS fill beats, then the retried read hits.
  task automatic read_miss(input string tag, input logic [31:0] a, input logic [31:0] exp);
    int r0;
    @(negedge clk);
    cpu_bus.rd = 1'b1; cpu_bus.wr = 1'b0; cpu_bus.addr = a;
    r0 = rd_acc;
    #1;
    chk({tag, "_miss_wait"}, {31'd0, cpu_bus.waitrequest}, 32'd1);
    chk({tag, "_miss_memrd"}, {31'd0, mem_bus.rd}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      chk({tag, "_fill_wait"}, {31'd0, cpu_bus.waitrequest}, 32'd1);
      chk({tag, "_fill_memrd"}, {31'd0, mem_bus.rd}, 32'd1);
      chk({tag, "_fill_addr"}, mem_bus.addr, a + 32'(4 * k));
    end
    @(negedge clk); #1;
    chk({tag, "_retry_wait"}, {31'd0, cpu_bus.waitrequest}, 32'd0);
    chk({tag, "_retry_data"}, cpu_bus.rd_data, exp);
    chk({tag, "_beats"}, 32'(rd_acc - r0), 32'd4);
  endtask

  logic [31:0] old_w;
  logic [31:0] st_w;
  int          r0, w0;

  initial begin
    rst = 1'b1;
    cpu_bus.rd = 1'b0; cpu_bus.wr = 1'b0; cpu_bus.addr = 32'd0;
    cpu_bus.wr_data = 32'd0; cpu_bus.wr_be = 4'd0;
    mem_bus.waitrequest = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_wait", {31'd0, cpu_bus.waitrequest}, 32'd0);
    chk("rst_memrd", {31'd0, mem_bus.rd}, 32'd0);
    chk("rst_memwr", {31'd0, mem_bus.wr}, 32'd0);
    chk("rst_memaddr", mem_bus.addr, 32'd0);

    // Cold read miss, then a hit in the same line without touching memory.
    read_miss("t1", 32'h100, pat(32'h100));
    @(negedge clk);
    cpu_bus.addr = 32'h108;
    r0 = rd_acc;
    #1;
    chk("t2_wait", {31'd0, cpu_bus.waitrequest}, 32'd0);
    chk("t2_data", cpu_bus.rd_data, pat(32'h108));
    chk("t2_memrd", {31'd0, mem_bus.rd}, 32'd0);
    @(negedge clk);
    cpu_bus.rd = 1'b0;
    #1;
    chk("t2_noacc", 32'(rd_acc - r0), 32'd0);

    // Store hit with two memory wait cycles.
    cpu_bus.wr = 1'b1; cpu_bus.addr = 32'h100;
    cpu_bus.wr_data = 32'hAB00_0000; cpu_bus.wr_be = 4'b1000;
    mem_bus.waitrequest = 1'b1;
    w0 = wr_acc;
    #1;
    chk("t3_wait1", {31'd0, cpu_bus.waitrequest}, 32'd1);
    chk("t3_memwr", {31'd0, mem_bus.wr}, 32'd1);
    chk("t3_be", {28'd0, mem_bus.wr_be}, 32'h8);
    chk("t3_addr", mem_bus.addr, 32'h100);
    chk("t3_wdata", mem_bus.wr_data, 32'hAB00_0000);
    @(negedge clk); #1;
    chk("t3_wait2", {31'd0, cpu_bus.waitrequest}, 32'd1);
    @(negedge clk);
    mem_bus.waitrequest = 1'b0;
    #1;
    chk("t3_wait3", {31'd0, cpu_bus.waitrequest}, 32'd0);
    @(negedge clk);
    cpu_bus.wr = 1'b0; cpu_bus.rd = 1'b1; cpu_bus.addr = 32'h100;
    old_w = pat(32'h100);
    st_w  = {8'hAB, old_w[23:0]};
    #1;
    chk("t3_rd_wait", {31'd0, cpu_bus.waitrequest}, 32'd0);
    chk("t3_rd_data", cpu_bus.rd_data, st_w);
    chk("t3_wr_once", 32'(wr_acc - w0), 32'd1);

    // Store miss: single write-through, no allocate.
    @(negedge clk);
    cpu_bus.rd = 1'b0; cpu_bus.wr = 1'b1; cpu_bus.addr = 32'h2000;
    cpu_bus.wr_data = 32'h1234_5678; cpu_bus.wr_be = 4'hF;
    w0 = wr_acc; r0 = rd_acc;
    #1;
    chk("t4_wait", {31'd0, cpu_bus.waitrequest}, 32'd0);
    chk("t4_memwr", {31'd0, mem_bus.wr}, 32'd1);
    @(negedge clk);
    cpu_bus.wr = 1'b0;
    #1;
    chk("t4_wr_once", 32'(wr_acc - w0), 32'd1);
    chk("t4_nofill", {31'd0, mem_bus.rd}, 32'd0);
    chk("t4_nofill_acc", 32'(rd_acc - r0), 32'd0);
    read_miss("t4", 32'h2000, 32'h1234_5678);

    // Conflict eviction on index 0x10.
    read_miss("t5a", 32'h500, pat(32'h500));
    read_miss("t5b", 32'h100, st_w);

    // Reset during a fill, after the second word has been accepted.
    read_miss("t6a", 32'h500, pat(32'h500));
    @(negedge clk);
    cpu_bus.addr = 32'h100;
    #1;
    chk("t6_miss", {31'd0, cpu_bus.waitrequest}, 32'd1);
    @(negedge clk); #1;
    chk("t6_w0", mem_bus.addr, 32'h100);
    @(negedge clk); #1;
    chk("t6_w1", mem_bus.addr, 32'h104);
    @(negedge clk);
    rst = 1'b1; cpu_bus.rd = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_rst_memrd", {31'd0, mem_bus.rd}, 32'd0);
    chk("t6_rst_wait", {31'd0, cpu_bus.waitrequest}, 32'd0);
    read_miss("t6b", 32'h100, st_w);

    @(negedge clk);
    cpu_bus.rd = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
